// File: rtl/kbd_key_fifo.sv
// Keyboard key FIFO: handshakes scancodes from a PS/2 decoder, filters them, queues presses.
// Latency: a push is visible on count/empty/dout one cycle after the capture edge; read pulses then too.
// Backpressure: none toward the decoder; presses arriving while full are dropped and flag overflow.
module kbd_key_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    scancode,
    input  logic          data_ready,
    input  logic          released,
    input  logic          err_ind,
    output logic          read,
    input  logic          rd_en,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic [7:0]    err_cnt
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ACK   = 2'd1;
    localparam logic [1:0]  ST_WAIT  = 2'd2;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_read;
    logic [7:0]    r_last_code;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_err_cnt;

    logic          w_capture;
    logic          w_push_req;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic          w_empty;
    logic          w_full;

    // Capture only from IDLE so a decoder event still held high in WAIT is not taken twice.
    assign w_capture  = (r_state == ST_IDLE) && data_ready;
    // A press qualifies for the queue when clean, a make code, mapped, and not a typematic repeat.
    assign w_push_req = w_capture && !err_ind && !released &&
                        (scancode != 8'h00) && (scancode != r_last_code);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == LP_DEPTH);
    assign w_pop      = rd_en && !w_empty;
    // When full, the slot being popped is the one being written, so push+pop is safe.
    assign w_wr       = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign read       = r_read;
    assign dout       = r_mem[r_rd_ptr];
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign err_cnt    = r_err_cnt;

    // Decoder handshake next-state: one ack cycle, then wait for data_ready to drop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (data_ready) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (!data_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake state and the registered read acknowledge (high exactly while in ACK).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_read  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_read  <= w_capture;
        end
    end

    // Classification side effects: last_code tracking and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_code <= 8'h00;
            r_err_cnt   <= 8'h00;
        end else if (w_capture) begin
            if (err_ind) begin
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else if (released) begin
                r_last_code <= 8'h00;
            end else if (w_push_req) begin
                // Updated even when the push is dropped for lack of space.
                r_last_code <= scancode;
            end
        end
    end

    // Queue storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= scancode;
    end

    // Pointers wrap naturally at AW bits; count is kept separately to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kbd_key_fifo.sv
// Bench for kbd_key_fifo: directed scenarios plus randomized handshakes against a queue model.
// Popped data is checked by an independent monitor against the expected-entry queue.
// Inputs change 1ns after rising edges; the monitor samples on falling edges.
module tb_kbd_key_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       data_ready = 1'b0;
    logic       released = 1'b0;
    logic       err_ind = 1'b0;
    logic       read;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf = 1'b0;
    logic [7:0] err_cnt;

    kbd_key_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .scancode(scancode), .data_ready(data_ready),
        .released(released), .err_ind(err_ind), .read(read), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued codes, last accepted code, sticky overflow, error count.
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovf = 1'b0;
    int         m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop the DUT performs must deliver the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h expected=none", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("pop_dout", dout, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = 8'h00;
        m_ovf  = 1'b0;
        m_err  = 0;
    endtask

    // Effect of one captured decoder frame on the model.
    task automatic model_capture(input logic [7:0] code, input bit rel, input bit err,
                                 input bit pop_now, input bit clr);
        bit drop;
        drop = 1'b0;
        if (err) begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
        end else if (rel) begin
            m_last = 8'h00;
        end else if (code != 8'h00 && code != m_last) begin
            m_last = code;
            if (exp_q.size() >= 16 && !pop_now) drop = 1'b1;
            else exp_q.push_back(code);
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, count, exp_q.size());
        chk({tag, "_empty"}, empty, exp_q.size() == 0);
        chk({tag, "_full"}, full, exp_q.size() == 16);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_errcnt"}, err_cnt, m_err);
        if (exp_q.size() > 0) chk({tag, "_dout"}, dout, exp_q[0]);
    endtask

    // One full decoder handshake; pop0 is rd_en on the capture cycle, pop_pct drives later cycles.
    task automatic hs(input logic [7:0] code, input bit rel, input bit err, input bit clr,
                      input bit pop0, input int pop_pct, input int hold);
        scancode   = code;
        released   = rel;
        err_ind    = err;
        data_ready = 1'b1;
        rd_en      = pop0;
        clr_ovf    = clr;
        model_capture(code, rel, err, pop0 && (exp_q.size() > 0), clr);
        tick();
        clr_ovf = 1'b0;
        rd_en   = ($urandom_range(0, 99) < pop_pct);
        chk("read_ack", read, 1'b1);
        check_state("cap");
        tick();
        chk("read_wait", read, 1'b0);
        for (int h = 0; h < hold; h++) begin
            rd_en = ($urandom_range(0, 99) < pop_pct);
            tick();
            chk("read_hold", read, 1'b0);
        end
        data_ready = 1'b0;
        rd_en      = ($urandom_range(0, 99) < pop_pct);
        tick();
        chk("read_idle", read, 1'b0);
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rd_en = 1'b1;
        while (exp_q.size() > 0 && guard < 40) begin
            tick();
            guard++;
        end
        rd_en = 1'b0;
        if (guard >= 40) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 left", exp_q.size());
        end
        chk("drain_empty", empty, 1'b1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_read", read, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_errcnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single press
        hs(8'h61, 0, 0, 0, 0, 0, 0);
        chk("p1_count", count, 1);
        chk("p1_dout", dout, 8'h61);

        // Repeat suppression and re-arm after release
        hs(8'h61, 0, 0, 0, 0, 0, 1);
        hs(8'h61, 0, 0, 0, 0, 0, 0);
        hs(8'h61, 1, 0, 0, 0, 0, 0);
        hs(8'h61, 0, 0, 0, 0, 0, 2);
        chk("rep_count", count, 2);
        drain();

        // Overfill with distinct codes
        for (int i = 0; i < 17; i++) hs(8'h10 + 8'(i), 0, 0, 0, 0, 0, 0);
        chk("ovf_full", full, 1'b1);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_dout", dout, 8'h10);
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 1'b0);

        // Push+pop while full, long enough to wrap both pointers several times
        for (int i = 0; i < 40; i++) hs(8'h30 + 8'(i), 0, 0, 0, 1, 0, 0);
        chk("pp_count", count, 16);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_full", full, 1'b1);
        drain();

        // Error frames saturate the counter and push nothing
        for (int i = 0; i < 300; i++) hs(8'h44, 0, 1, 0, 0, 0, 0);
        chk("err_sat", err_cnt, 255);
        chk("err_count", count, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check_state("pop_empty");

        // Randomized traffic: small code alphabet to hit repeats, zero codes and releases
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 7);
            c = (r == 0) ? 8'h00 : 8'h20 + 8'(r);
            hs(c, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
               (i < 120) ? 10 : 40, $urandom_range(0, 2));
        end
        check_state("rnd_end");
        drain();

        // Reset in the ACK cycle with data_ready held high
        scancode   = 8'h33;
        released   = 1'b0;
        err_ind    = 1'b0;
        data_ready = 1'b1;
        tick();
        chk("mid_ack", read, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_read", read, 1'b0);
        check_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_capture(8'h33, 0, 0, 0, 0);
        tick();
        chk("post_read", read, 1'b1);
        check_state("post_cap");
        tick();
        chk("post_read_lo", read, 1'b0);
        data_ready = 1'b0;
        tick();
        tick();
        chk("post_read_idle", read, 1'b0);
        check_state("post_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_key_fifo.md
KBD_KEY_FIFO -- requirements
Module: kbd_key_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; log2(DEPTH).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 scancode  in  8  key code from the PS/2 decoder, valid while data_ready=1.
REQ-006 data_ready  in  1  decoder holds a code; held high until read is seen.
REQ-007 released  in  1  code is a break (key-up) event.
REQ-008 err_ind  in  1  frame had a parity or start/stop error.
REQ-009 read  out  1  registered one-cycle acknowledge to the decoder.
REQ-010 rd_en  in  1  consumer pop request.
REQ-011 dout  out  8  head entry, first-word-fall-through; undefined when empty=1.
REQ-012 empty  out  1  count==0.
REQ-013 full  out  1  count==DEPTH.
REQ-014 count  out  AW+1  entries held.
REQ-015 overflow  out  1  sticky: an accepted press was dropped because the FIFO was full.
REQ-016 clr_ovf  in  1  synchronous clear of overflow.
REQ-017 err_cnt  out  8  saturating count of frames received with err_ind=1.

Function
REQ-018 Handshake FSM states: IDLE, ACK, WAIT; reset state IDLE.
REQ-019 IDLE -> ACK when data_ready=1; inputs are sampled on that edge (capture edge).
REQ-020 In ACK, read=1 for exactly one cycle; ACK -> WAIT unconditionally.
REQ-021 In WAIT, read=0; WAIT -> IDLE when data_ready=0; a data_ready still high in WAIT is never re-captured.
REQ-022 Each decoder event is captured at most once; read is never high in IDLE or WAIT.
REQ-023 Classification on the capture edge, in priority order:
  - err_ind=1: err_cnt += 1, saturating at 255; no push; last_code unchanged.
  - released=1: no push; last_code cleared to 0x00.
  - scancode==0x00: no push (unmapped or modifier-only code).
  - scancode==last_code: no push (typematic repeat suppression).
  - otherwise: push the scancode; last_code = scancode.
REQ-024 A push is written on the capture edge; count, empty, and dout reflect it on the following cycle.
REQ-025 Pop occurs when rd_en=1 and empty=0; rd_en while empty is ignored and has no side effect.
REQ-026 Simultaneous push and pop: both take effect, count unchanged; allowed while full.
REQ-027 Push when full with no pop in the same cycle: data dropped, overflow set to 1, last_code still updated, count unchanged.
REQ-028 clr_ovf=1 clears overflow on the next edge; if a drop occurs in the same cycle, set wins.
REQ-029 Read and write pointers are AW bits wide and wrap from DEPTH-1 to 0; count is derived independently so that full and empty are unambiguous.
REQ-030 dout = mem[rd_ptr] combinationally; after a pop it shows the next entry the following cycle.

Reset
REQ-031 While rst_n=0: state=IDLE, read=0, count=0, empty=1, full=0, overflow=0, err_cnt=0, last_code=0x00, pointers=0; memory contents are don't-care.
REQ-032 Reset asserted mid-handshake abandons the event; after release the FSM starts in IDLE and re-captures a still-high data_ready.

Verification
REQ-033 Press 0x61, data_ready high until read -> read pulses once 1 cycle after capture; count=1; dout=0x61.
REQ-034 0x61 press x3, then released 0x61, then 0x61 press -> exactly two 0x61 entries pushed.
REQ-035 17 distinct presses with no pops (DEPTH=16) -> full=1, count=16, overflow=1, dout=first code; clr_ovf -> overflow=0.
REQ-036 Full FIFO, push and rd_en in the same cycle -> count stays 16, overflow=0, new code is the tail entry, pointers wrap correctly across 40 cycles of push+pop.
REQ-037 300 frames with err_ind=1 -> err_cnt=255, count=0; rd_en on empty -> no change.
REQ-038 rst_n pulled low during ACK with data_ready held high -> all outputs at reset values; after release one new capture and one read pulse.
